// File: rtl/register_seq.sv
// register_seq: chunks load/shift/rotate commands onto the shift register; REGISTER_SEQ_STAT_EN adds stat_cnt/stat_busy_cycles
module register_seq #(
    parameter int MAX_STEP  = 15,
    parameter int HOLD_CODE = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [4:0]  cmd_amt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  reg_set,
    output logic [3:0]  reg_M,
    output logic [15:0] reg_D,
    input  logic [15:0] reg_Q
`ifdef REGISTER_SEQ_STAT_EN
    ,
    output logic [15:0] stat_cnt,
    output logic [15:0] stat_busy_cycles
`endif
);
    localparam logic [2:0] HOLD = 3'(HOLD_CODE);
    localparam logic [3:0] STEP = 4'(MAX_STEP);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] op;
    logic [15:0] data;
    logic [4:0] rem;
    logic [4:0] amt_in;
    logic [3:0] step;
    logic take;
    logic done;
    assign take = cmd_valid && state == IDLE;
    assign amt_in = cmd_op == 2'd3 ? {1'b0, cmd_amt[3:0]} : cmd_amt;
    assign step = rem > {1'b0, STEP} ? STEP : rem[3:0];
    assign done = rsp_valid && rsp_ready;
    always_ff @(posedge clk)
        if (!res) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        reg_set = HOLD;
        reg_M = '0;
        reg_D = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (take) state_nxt = (cmd_op != 2'd0 && amt_in == 5'd0) ? RESP : ISSUE;
            end
            ISSUE: begin
                reg_set = {1'b0, op};
                reg_M = op == 2'd0 ? 4'd0 : step;
                reg_D = op == 2'd0 ? data : 16'd0;
                if (op == 2'd0 || rem == {1'b0, step}) state_nxt = RESP;
            end
            RESP: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // rsp_valid low in RESP marks the capture cycle: reg_Q is valid one cycle after the last issue
    always_ff @(posedge clk)
        if (!res) begin
            op <= '0;
            data <= '0;
            rem <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (take) begin
                op <= cmd_op;
                data <= cmd_data;
                rem <= amt_in;
            end
            if (state == ISSUE && op != 2'd0) rem <= rem - {1'b0, step};
            if (state == RESP && !rsp_valid) begin
                rsp_valid <= 1'b1;
                rsp_data <= reg_Q;
            end
            if (done) rsp_valid <= 1'b0;
        end
`ifdef REGISTER_SEQ_STAT_EN
    always_ff @(posedge clk)
        if (!res) begin
            stat_cnt <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (done) stat_cnt <= stat_cnt + 16'd1;
            if (state == ISSUE && stat_busy_cycles != 16'hFFFF) stat_busy_cycles <= stat_busy_cycles + 16'd1;
        end
`endif
endmodule

// File: tb/tb_register_seq.sv
// tb_register_seq: directed vectors for register_seq driving a behavioural shift register
module tb_register_seq;
    logic clk = 1'b0;
    logic res = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [15:0] cmd_data = '0;
    logic [4:0] cmd_amt = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0] reg_set;
    logic [3:0] reg_M;
    logic [15:0] reg_D;
    logic [15:0] q = '0;
    logic [31:0] rot;
`ifdef REGISTER_SEQ_STAT_EN
    logic [15:0] stat_cnt;
    logic [15:0] stat_busy_cycles;
`endif
    int errors = 0;
    int checks = 0;
    int hs = 0;

    typedef struct {
        logic [1:0] op;
        logic [15:0] data;
        logic [4:0] amt;
        logic [15:0] rsp;
        int lat;
        int nis;
        int m0;
    } vec_t;
    vec_t vecs[19];

    register_seq dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .reg_set(reg_set), .reg_M(reg_M), .reg_D(reg_D), .reg_Q(q)
`ifdef REGISTER_SEQ_STAT_EN
        , .stat_cnt(stat_cnt), .stat_busy_cycles(stat_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign rot = {q, q} << reg_M;
    always @(posedge clk)
        case (reg_set)
            3'd0: q <= reg_D;
            3'd1: q <= q << reg_M;
            3'd2: q <= q >> reg_M;
            3'd3: q <= rot[31:16];
            default: q <= q;
        endcase

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input vec_t v, input int bp);
        int cyc;
        int nis;
        bit bad_ready;
        cmd_valid = 1'b1;
        cmd_op = v.op;
        cmd_data = v.data;
        cmd_amt = v.amt;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'd3;
        cmd_data = 16'hDEAD;
        cmd_amt = 5'd9;
        cyc = 0;
        nis = 0;
        bad_ready = 1'b0;
        while (!rsp_valid && cyc < 40) begin
            cyc++;
            if (cmd_ready) bad_ready = 1'b1;
            if (reg_set != 3'd4) begin
                nis++;
                chk("issue_set", reg_set, v.op);
                if (nis == 1 && v.op == 2'd0) chk("load_D", reg_D, v.data);
                if (nis == 1 && v.op != 2'd0) chk("first_M", reg_M, v.m0);
            end
            @(posedge clk); #1;
        end
        chk("latency", cyc + 1, v.lat);
        chk("issue_cycles", nis, v.nis);
        chk("busy_not_ready", bad_ready, 0);
        chk("rsp_data", rsp_data, v.rsp);
        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, v.rsp);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_set_hold", reg_set, 4);
`ifdef REGISTER_SEQ_STAT_EN
            chk("bp_stat_cnt", stat_cnt, hs);
`endif
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        hs++;
        chk("rsp_released", rsp_valid, 0);
        chk("ready_again", cmd_ready, 1);
`ifdef REGISTER_SEQ_STAT_EN
        chk("stat_cnt", stat_cnt, hs);
`endif
    endtask

    initial begin
        bit seen;
        vec_t v;
        vecs = '{
            '{2'd0, 16'h0269, 5'd0,  16'h0269, 3, 1, 0},
            '{2'd1, 16'h0000, 5'd3,  16'h1348, 3, 1, 3},
            '{2'd0, 16'hFFFF, 5'd0,  16'hFFFF, 3, 1, 0},
            '{2'd2, 16'h0000, 5'd20, 16'h0000, 4, 2, 15},
            '{2'd0, 16'h8001, 5'd0,  16'h8001, 3, 1, 0},
            '{2'd3, 16'h0000, 5'd17, 16'h0003, 3, 1, 1},
            '{2'd3, 16'h0000, 5'd0,  16'h0003, 2, 0, 0},
            '{2'd1, 16'h0000, 5'd0,  16'h0003, 2, 0, 0},
            '{2'd0, 16'h1234, 5'd0,  16'h1234, 3, 1, 0},
            '{2'd2, 16'h0000, 5'd15, 16'h0000, 3, 1, 15},
            '{2'd0, 16'hABCD, 5'd0,  16'hABCD, 3, 1, 0},
            '{2'd3, 16'h0000, 5'd16, 16'hABCD, 2, 0, 0},
            '{2'd0, 16'h00F0, 5'd0,  16'h00F0, 3, 1, 0},
            '{2'd1, 16'h0000, 5'd16, 16'h0000, 4, 2, 15},
            '{2'd0, 16'h8000, 5'd0,  16'h8000, 3, 1, 0},
            '{2'd2, 16'h0000, 5'd31, 16'h0000, 5, 3, 15},
            '{2'd0, 16'h1234, 5'd0,  16'h1234, 3, 1, 0},
            '{2'd3, 16'h0000, 5'd4,  16'h2341, 3, 1, 4},
            '{2'd2, 16'h0000, 5'd7,  16'h0046, 3, 1, 7}
        };
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_reg_set", reg_set, 4);
        chk("rst_reg_M", reg_M, 0);
        chk("rst_reg_D", reg_D, 0);
`ifdef REGISTER_SEQ_STAT_EN
        chk("rst_stat_cnt", stat_cnt, 0);
`endif
        res = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) run_cmd(vecs[i], 0);
        v = '{2'd0, 16'h0003, 5'd0, 16'h0003, 3, 1, 0};
        run_cmd(v, 0);
        v = '{2'd1, 16'h0000, 5'd1, 16'h0006, 3, 1, 1};
        run_cmd(v, 3);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_amt = 5'd31;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("abort_issue1_M", reg_M, 15);
        @(posedge clk); #1;
        chk("abort_issue2_M", reg_M, 15);
        res = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        hs = 0;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_reg_set", reg_set, 4);
        chk("abort_reg_M", reg_M, 0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid || reg_set != 3'd4) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 0);
        v = '{2'd0, 16'h5A5A, 5'd0, 16'h5A5A, 3, 1, 0};
        run_cmd(v, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_seq.md
Name: register_seq

Overview:
- Command sequencer (initiator) for the 16-bit multi-mode shift register; the register is the responder.
- Accepts high-level load/shift/rotate commands over a valid/ready handshake.
- Drives the register's set/M/D inputs cycle by cycle, splitting long shifts into legal chunks.
- Captures the register output and returns it as a response.
- Sits between the datapath control logic and the register instance.

Parameters:
- MAX_STEP, 15: largest shift amount issued per cycle on reg_M; legal range 1..15.
- HOLD_CODE, 4: set code driven whenever no operation is issued.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- res  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0 = load, 1 = shift left logical, 2 = shift right logical, 3 = rotate left.
- cmd_data  in  16  load value; ignored for shift ops.
- cmd_amt  in  5  shift/rotate amount, 0..31.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  16  register contents after the command.
- reg_set  out  3  register mode: 0 load, 1 shl, 2 shr, 3 rol, HOLD_CODE hold.
- reg_M  out  4  per-cycle shift count to the register.
- reg_D  out  16  parallel load data to the register.
- reg_Q  in  16  register outstate.

Behaviour:
- Reset (res=0 at an edge) puts the block in IDLE with these outputs:
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
  - reg_set=HOLD_CODE, reg_M=0, reg_D=0.
  - This applies from any state; an in-flight command is dropped, and no response is produced for it.
- The register updates on the same edge that ends a cycle in which reg_set is a non-hold code. Its reg_Q is valid in the following cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - A transfer happens when cmd_valid && cmd_ready. On that edge the block latches op, data and amount:
    - rol: amount is reduced mod 16.
    - shl/shr: amount is kept at 0..31, so amounts of 16 and above clear the word naturally via chunks.
  - Next state: load → ISSUE; shift with latched amount 0 → RESP; otherwise → ISSUE.
- ISSUE:
  - cmd_ready=0.
  - load: reg_set=0, reg_D=data, reg_M=0, for exactly one cycle, then → RESP.
  - shift/rotate: reg_set=op code, reg_M=min(remaining, MAX_STEP). Decrement remaining by that amount each cycle; → RESP when it reaches 0.
  - Number of ISSUE cycles = ceil(amt/MAX_STEP).
- RESP:
  - reg_set=HOLD_CODE, reg_M=0.
  - On the entry cycle: rsp_data <= reg_Q (registered), and rsp_valid=1 from the following cycle.
  - rsp_valid and rsp_data stay stable until rsp_ready=1. On the edge with rsp_valid && rsp_ready → IDLE.
  - cmd_ready=0 throughout.
- Latency from the acceptance edge to the first cycle rsp_valid=1:
  - load: 3 cycles.
  - shift with amt 0: 2 cycles.
  - shift with n chunks: n+2 cycles.
- No command overlap: one outstanding command at a time.
- Outside ISSUE, reg_set is always HOLD_CODE, so the register never changes spontaneously.
- cmd_op/cmd_data/cmd_amt are ignored unless a transfer occurs.

Optional Feature:
- Macro: REGISTER_SEQ_STAT_EN.
- Defined:
  - Extra output port stat_cnt (16 bits), reset to 0.
  - Increments by 1 on each completed response handshake and wraps 0xFFFF → 0x0000.
  - Extra output stat_busy_cycles (16 bits) counts cycles spent in ISSUE; it saturates at 0xFFFF.
- Not defined: neither port exists and no counter logic is synthesized. Functional behaviour is otherwise identical.

Test Plan:
- Bench instantiates register_seq wired to the register block. Release reset, then command load 0x0269 → reg_set=0 with reg_D=0x0269 for one cycle; rsp_data=0x0269, rsp_valid 3 cycles after acceptance.
- After load 0x0269, shl amt=3 → one ISSUE cycle with reg_M=3; rsp_data=0x1348.
- Load 0xFFFF, then shr amt=20 → ISSUE cycles with reg_M=15, then 5; rsp_data=0x0000; rsp_valid 4 cycles after acceptance.
- Load 0x8001, then rol amt=17 → reduced to 1, single reg_M=1 cycle; rsp_data=0x0003. Then rol amt=0 → no ISSUE cycle; rsp_data=0x0003 after 2 cycles.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid → rsp_valid and rsp_data stable, cmd_ready=0, a new cmd_valid not accepted. With REGISTER_SEQ_STAT_EN, stat_cnt increments only on the handshake.
- Drive res=0 during the second ISSUE cycle of shl amt=31 → next cycle state IDLE, cmd_ready=1, rsp_valid=0, reg_set=4, reg_M=0; no response emitted.
